pad_cfg_sequencer: RTL and testbench
====================================

Name: pad_cfg_sequencer

Overview:
- Serialises runtime pad configuration updates for the pad ring. The pad ring itself is a combinational array of N_IO pads, each with an N-bit config word and an output enable.
- Sits between the SoC pad-control register file (requester) and the pad ring.
- Owns the registered pad_cfg bus. Gates per-pad output enables so that a pad being reconfigured is tristated before and after its config word changes, which prevents glitches and contention on the board.

Parameters:
- N_IO, 64: number of pads.
- NBIT_PADCFG, 6: config bits per pad; bit 0 is the pull enable.
- SETTLE_CYCLES, 16: isolation cycles before and after a config write; a value of 0 is treated as 1.
- RESET_CFG, 0: reset value of every pad config word, NBIT_PADCFG wide.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  update request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_idx_i  in  $clog2(N_IO)  target pad index.
- req_cfg_i  in  NBIT_PADCFG  new config word.
- io_oe_i  in  N_IO  output enables from the peripheral mux.
- io_oe_o  out  N_IO  gated output enables to the pad ring.
- pad_cfg_o  out  N_IO*NBIT_PADCFG  registered config, one word per pad, to the pad ring.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse on sequence completion.
- err_o  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset state (asynchronous, while rst_ni=0):
  - state=IDLE; isolation mask=0; counter=0.
  - Every pad_cfg_o word = RESET_CFG.
  - busy_o=0, done_o=0, err_o=0, req_ready_o=0.
  - io_oe_o = io_oe_i, since the mask is clear.
- req_ready_o=1 only in state IDLE with rst_ni=1. A handshake is valid&ready in a cycle; idx and cfg are latched in that cycle.
- io_oe_o = io_oe_i & ~mask. This is combinational from the registered mask, so there is no added latency on the enable path.
- busy_o=1 in every state except IDLE.
- FSM (the handshake happens in cycle 0; S = max(SETTLE_CYCLES,1)):
  - IDLE, on handshake:
    - req_idx_i >= N_IO -> REJECT.
    - req_cfg_i == pad_cfg_o[req_idx_i] -> DONE. No isolation, no write.
    - otherwise -> ISOLATE; mask[idx] is set, registered, and effective from cycle 1.
  - ISOLATE: holds for S cycles (cycles 1..S) on a down-counter, then -> APPLY.
  - APPLY: one cycle (cycle S+1). pad_cfg_o[idx] is written at the end of this cycle and shows the new value from cycle S+2. No other pad word changes.
  - HOLD: S cycles (S+2..2S+1) with the mask still set, then -> DONE, clearing mask[idx] on entry.
  - DONE: one cycle. done_o=1; io_oe_o[idx] follows io_oe_i again in this cycle. Then -> IDLE; req_ready_o=1 from the next cycle.
  - REJECT: one cycle. err_o=1, no state change to the mask or pad_cfg_o, done_o stays 0. Then -> IDLE.
- Latency:
  - Full sequence: done_o at cycle 2S+2; next accept possible at 2S+3.
  - Same-config request: done_o at cycle 1.
  - Rejected request: err_o at cycle 1.
- At most one bit of the mask is ever set. There is no queuing; back-pressure is via req_ready_o only.
- Changes on io_oe_i during a sequence pass through to every pad except idx.
- req_valid_i held high with new data while busy is ignored; only the value present at the handshake is used.
- Reset mid-sequence: immediate return to reset state. The mask clears and all pad_cfg_o words return to RESET_CFG, including words written before the reset. No done_o pulse.
- The counter is wide enough for S: $clog2(S+1) bits, saturating-free down-count.

Test Plan:
- Reset values (S=4, RESET_CFG=0, io_oe_i=all ones): assert rst_ni=0 -> pad_cfg_o all 0, io_oe_o all ones, req_ready_o=0, busy_o=0. Release reset -> req_ready_o=1 next cycle.
- Normal update (S=4): request idx=5, cfg=6'h01 in cycle 0. Required response:
  - io_oe_o[5]=0 in cycles 1..9, all other io_oe_o bits equal io_oe_i.
  - pad_cfg_o[5]=6'h01 from cycle 6, unchanged at 6'h00 in cycles 1..5.
  - done_o=1 only in cycle 10, io_oe_o[5]=io_oe_i[5] again in cycle 10.
  - req_ready_o=1 in cycle 11.
- Redundant request: request idx=5, cfg=6'h01 again -> done_o in cycle 1, io_oe_o[5] never deasserted, pad_cfg_o unchanged.
- Rejected request (N_IO=48, idx width 6): request idx=50 -> err_o pulse in cycle 1, done_o=0, no pad_cfg_o or io_oe_o change.
- Back-pressure and toggling (S=4):
  - Hold req_valid_i=1 continuously with idx=3 then idx=7 -> second request accepted exactly in cycle 11; no mask overlap.
  - Toggle io_oe_i[7] during the first sequence -> io_oe_o[7] follows it each cycle.
- Reset mid-sequence: assert rst_ni=0 in cycle 7 of a pad 5 update to 6'h3F (after the write in cycle 5) -> pad_cfg_o[5]=RESET_CFG and mask clear immediately. No done_o; clean accept of a new request after reset release.

Source files
------------

// File: rtl/pad_cfg_sequencer_if.sv
// rtl/pad_cfg_sequencer_if.sv - request, output-enable and pad config bundle for pad_cfg_sequencer
interface pad_cfg_sequencer_if #(
    parameter int N_IO        = 64,
    parameter int NBIT_PADCFG = 6,
    parameter int IDX_W       = (N_IO > 1) ? $clog2(N_IO) : 1
);
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [IDX_W-1:0]              req_idx_i;
    logic [NBIT_PADCFG-1:0]        req_cfg_i;
    logic [N_IO-1:0]               io_oe_i;
    logic [N_IO-1:0]               io_oe_o;
    logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_o;
    logic                          busy_o;
    logic                          done_o;
    logic                          err_o;

    modport master (
        output req_valid_i, req_idx_i, req_cfg_i, io_oe_i,
        input  req_ready_o, io_oe_o, pad_cfg_o, busy_o, done_o, err_o
    );

    modport slave (
        input  req_valid_i, req_idx_i, req_cfg_i, io_oe_i,
        output req_ready_o, io_oe_o, pad_cfg_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/pad_cfg_sequencer.sv
// rtl/pad_cfg_sequencer.sv - serialises pad config writes with output-enable isolation around each write
module pad_cfg_sequencer #(
    parameter int                     N_IO          = 64,
    parameter int                     NBIT_PADCFG   = 6,
    parameter int                     SETTLE_CYCLES = 16,
    parameter logic [NBIT_PADCFG-1:0] RESET_CFG     = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pad_cfg_sequencer_if.slave   bus
);
    localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam int S     = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(S + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(S - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_APPLY,
        ST_HOLD,
        ST_DONE,
        ST_REJECT
    } state_t;

    state_t                                 state_q;
    logic [CNT_W-1:0]                       cnt_q;
    logic [N_IO-1:0]                        mask_q;
    logic [IDX_W-1:0]                       idx_q;
    logic [NBIT_PADCFG-1:0]                 cfg_new_q;
    logic [N_IO-1:0][NBIT_PADCFG-1:0]       cfg_q;
    logic                                   ready_q;
    logic                                   busy_q;
    logic                                   done_q;
    logic                                   err_q;

    logic                                   idx_ok;
    logic                                   handshake;
    logic [NBIT_PADCFG-1:0]                 cur_cfg;

    // A power-of-two pad count makes every encodable index legal.
    generate
        if (N_IO == (1 << IDX_W)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_range
            assign idx_ok = ({1'b0, bus.req_idx_i} < (IDX_W + 1)'(N_IO));
        end
    endgenerate

    assign handshake = bus.req_valid_i && ready_q;
    assign cur_cfg   = idx_ok ? cfg_q[bus.req_idx_i] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            cfg_new_q <= '0;
            cfg_q     <= {N_IO{RESET_CFG}};
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (handshake) begin
                        idx_q     <= bus.req_idx_i;
                        cfg_new_q <= bus.req_cfg_i;
                        cnt_q     <= CNT_LOAD;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (!idx_ok) begin
                            state_q <= ST_REJECT;
                            err_q   <= 1'b1;
                        end else if (bus.req_cfg_i == cur_cfg) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISOLATE;
                            mask_q  <= N_IO'(1) << bus.req_idx_i;
                        end
                    end
                end
                ST_ISOLATE: begin
                    if (cnt_q == '0) state_q <= ST_APPLY;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_APPLY: begin
                    cfg_q[idx_q] <= cfg_new_q;
                    cnt_q        <= CNT_LOAD;
                    state_q      <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Release the pad on entry to DONE so it drives again in the done cycle.
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        mask_q  <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE, ST_REJECT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    mask_q  <= '0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.io_oe_o     = bus.io_oe_i & ~mask_q;
    assign bus.pad_cfg_o   = cfg_q;
endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// tb/tb_pad_cfg_sequencer.sv - randomized self-checking bench for pad_cfg_sequencer
module tb_pad_cfg_sequencer;
    localparam int N_IO = 48;
    localparam int NB   = 6;
    localparam int S    = 4;
    localparam int IW   = 6;
    localparam int W    = N_IO * NB;
    localparam logic [NB-1:0] RCFG = 6'h00;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pad_cfg_sequencer_if #(.N_IO(N_IO), .NBIT_PADCFG(NB)) bus ();

    pad_cfg_sequencer #(
        .N_IO(N_IO), .NBIT_PADCFG(NB), .SETTLE_CYCLES(S), .RESET_CFG(RCFG)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [NB-1:0] m_cfg [N_IO];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_pads();
        logic [W-1:0] v;
        for (int i = 0; i < N_IO; i++) v[i*NB +: NB] = m_cfg[i];
        return v;
    endfunction

    function automatic logic [N_IO-1:0] rand_oe();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N_IO-1:0];
    endfunction

    // One request from its accept cycle (0) through its done/err cycle; returns
    // just after the edge that starts the cycle in which ready must be back.
    task automatic run_seq(input int idx, input logic [NB-1:0] cfg,
                           input bit hold, input int nidx, input logic [NB-1:0] ncfg);
        int kind;
        int last;
        logic [N_IO-1:0] eoe;
        bus.req_valid_i = 1'b1;
        bus.req_idx_i   = IW'(idx);
        bus.req_cfg_i   = cfg;
        bus.io_oe_i     = rand_oe();
        @(negedge clk);
        chk("ready_c0", W'(bus.req_ready_o), W'(1'b1));
        chk("oe_c0", W'(bus.io_oe_o), W'(bus.io_oe_i));
        chk("pads_c0", bus.pad_cfg_o, model_pads());
        if (idx >= N_IO)             kind = 2;
        else if (m_cfg[idx] == cfg)  kind = 1;
        else                         kind = 0;
        last = (kind == 0) ? 2*S + 2 : 1;
        @(posedge clk); #1;
        if (hold) begin
            bus.req_idx_i = IW'(nidx);
            bus.req_cfg_i = ncfg;
        end else begin
            bus.req_valid_i = 1'b0;
            bus.req_idx_i   = IW'($urandom_range(0, 63));
            bus.req_cfg_i   = NB'($urandom_range(0, 63));
        end
        for (int c = 1; c <= last; c++) begin
            bus.io_oe_i    = rand_oe();
            bus.io_oe_i[7] = c[0];
            if (kind == 0 && c == S + 2) m_cfg[idx] = cfg;
            @(negedge clk);
            eoe = bus.io_oe_i;
            if (kind == 0 && c <= 2*S + 1) eoe[idx] = 1'b0;
            chk($sformatf("oe_c%0d", c),    W'(bus.io_oe_o), W'(eoe));
            chk($sformatf("pads_c%0d", c),  bus.pad_cfg_o, model_pads());
            chk($sformatf("done_c%0d", c),  W'(bus.done_o), W'(kind != 2 && c == last));
            chk($sformatf("err_c%0d", c),   W'(bus.err_o),  W'(kind == 2 && c == 1));
            chk($sformatf("busy_c%0d", c),  W'(bus.busy_o), W'(1'b1));
            chk($sformatf("ready_c%0d", c), W'(bus.req_ready_o), W'(1'b0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int ridx;
        int r;
        logic [NB-1:0] rcfg;
        for (int i = 0; i < N_IO; i++) m_cfg[i] = RCFG;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_idx_i   = '0;
        bus.req_cfg_i   = '0;
        bus.io_oe_i     = '1;
        repeat (3) @(negedge clk);
        chk("rst_pads",  bus.pad_cfg_o, model_pads());
        chk("rst_oe",    W'(bus.io_oe_o), W'({N_IO{1'b1}}));
        chk("rst_ready", W'(bus.req_ready_o), W'(1'b0));
        chk("rst_busy",  W'(bus.busy_o), W'(1'b0));
        chk("rst_done",  W'(bus.done_o), W'(1'b0));
        chk("rst_err",   W'(bus.err_o), W'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", W'(bus.req_ready_o), W'(1'b0));
        @(posedge clk); #1;

        run_seq(5, 6'h01, 1'b0, 0, 6'h00);
        run_seq(5, 6'h01, 1'b0, 0, 6'h00);
        run_seq(50, 6'h15, 1'b0, 0, 6'h00);
        run_seq(3, 6'h2A, 1'b1, 7, 6'h15);
        run_seq(7, 6'h15, 1'b0, 0, 6'h00);

        // Reset in cycle 7 of a pad 5 update, after the new word has landed.
        bus.req_valid_i = 1'b1;
        bus.req_idx_i   = IW'(5);
        bus.req_cfg_i   = 6'h3F;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            bus.io_oe_i = rand_oe();
            if (c == 6) m_cfg[5] = 6'h3F;
            @(negedge clk);
            chk($sformatf("mr_pads_c%0d", c), bus.pad_cfg_o, model_pads());
            chk($sformatf("mr_oe5_c%0d", c),  W'(bus.io_oe_o[5]), W'(1'b0));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        for (int i = 0; i < N_IO; i++) m_cfg[i] = RCFG;
        #1;
        chk("mr_pads", bus.pad_cfg_o, model_pads());
        chk("mr_oe",   W'(bus.io_oe_o), W'(bus.io_oe_i));
        chk("mr_busy", W'(bus.busy_o), W'(1'b0));
        @(negedge clk);
        chk("mr_done",  W'(bus.done_o), W'(1'b0));
        chk("mr_ready", W'(bus.req_ready_o), W'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rel_ready", W'(bus.req_ready_o), W'(1'b0));
        @(posedge clk); #1;
        run_seq(9, 6'h2C, 1'b0, 0, 6'h00);

        for (int k = 0; k < 12; k++) begin
            r    = $urandom_range(0, 9);
            ridx = $urandom_range(0, N_IO - 1);
            rcfg = NB'($urandom_range(0, 63));
            if (r == 0)      ridx = $urandom_range(N_IO, 63);
            else if (r <= 2) rcfg = m_cfg[ridx];
            run_seq(ridx, rcfg, 1'b0, 0, 6'h00);
        end

        @(negedge clk);
        chk("end_ready", W'(bus.req_ready_o), W'(1'b1));
        chk("end_busy",  W'(bus.busy_o), W'(1'b0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
